ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu.sv | 107 ++++++++++
 tb/tb_ifu.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: a three-state fetch engine with at most one outstanding
// memory request, a single-entry instruction holding register, and redirect handling.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Handshakes: imem_req/imem_gnt transfer an address when both are high on a rising
  // edge; imem_rvalid returns data only while WAIT; inst_valid/inst_ready transfer inst
  // when both are high; inst_valid never drops without a transfer except on redirect.
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] redirect_target;

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_gnt) state_d = S_WAIT;
        if (redirect) begin
          pc_d = redirect_target;
          // A granted request already carries the stale address; drop its response.
          if (imem_gnt) discard_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d   = S_FETCH;
          discard_d = 1'b0;
          if (redirect) begin
            pc_d = redirect_target;
          end else if (!discard_q) begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            state_d   = S_HOLD;
          end
        end else if (redirect) begin
          pc_d      = redirect_target;
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = S_FETCH;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == S_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: scenario tasks drive the memory/decoder side cycle by cycle; a
// negedge monitor checks every accepted instruction against the expected queue.
module tb_ifu;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] model_pc;

  ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end, required end of test");
    $fatal(1);
  end

  // scoreboard: every accepted instruction must match the head of the expected queue
  always @(negedge clock) begin
    if (!reset && inst_valid && inst_ready) begin
      n_cmp++;
      if (exp_inst_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got inst=%h pc=%h, required no instruction", inst, inst_pc);
      end else begin
        logic [31:0] ei, ep;
        ei = exp_inst_q.pop_front();
        ep = exp_pc_q.pop_front();
        if ({inst, inst_pc} !== {ei, ep}) begin
          n_err++;
          $display("FAIL sb_inst: got inst=%h pc=%h, required inst=%h pc=%h", inst, inst_pc, ei, ep);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // driver: one full fetch at model_pc, with optional grant delay and decoder stall
  task automatic do_fetch(input logic [31:0] data, input int gnt_delay, input int stall);
    for (int i = 0; i < gnt_delay; i++) begin
      chk("fetch_req_pending", {31'h0, imem_req}, 32'h1);
      tick();
    end
    chk("fetch_req", {31'h0, imem_req}, 32'h1);
    chk("fetch_addr", imem_addr, model_pc);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("wait_no_req", {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    exp_inst_q.push_back(data);
    exp_pc_q.push_back(model_pc);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("hold_valid", {31'h0, inst_valid}, 32'h1);
    chk("hold_inst", inst, data);
    chk("hold_pc", inst_pc, model_pc);
    for (int i = 0; i < stall; i++) begin
      imem_rvalid = $urandom_range(0, 1);
      tick();
      chk("stall_valid", {31'h0, inst_valid}, 32'h1);
      chk("stall_inst", inst, data);
      chk("stall_pc", inst_pc, model_pc);
      chk("stall_no_req", {31'h0, imem_req}, 32'h0);
    end
    imem_rvalid = 1'b0;
    inst_ready  = 1'b1;
    tick();
    inst_ready = 1'b0;
    model_pc   = model_pc + 32'd4;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h1234_5678;
    imem_gnt = 1'b1;
    imem_rvalid = 1'b1;
    inst_ready = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    repeat (3) tick();
    reset = 1'b0;
    redirect = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    inst_ready = 1'b0;
    chk("rst_req", {31'h0, imem_req}, 32'h1);
    chk("rst_addr", imem_addr, 32'h8000_0000);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, 32'h0);
    model_pc = 32'h8000_0000;
  endtask

  task automatic test_basic();
    do_fetch(32'h0000_0513, 0, 0);
    chk("basic_next_addr", imem_addr, 32'h8000_0004);
    chk("basic_next_req", {31'h0, imem_req}, 32'h1);
  endtask

  task automatic test_stall();
    do_fetch(32'h00A0_0093, 0, 5);
    chk("stall_next_addr", imem_addr, 32'h8000_0008);
  endtask

  task automatic test_gnt_wait();
    for (int i = 0; i < 10; i++) begin
      imem_rvalid = $urandom_range(0, 1);
      imem_rdata  = $urandom;
      tick();
      chk("nognt_req", {31'h0, imem_req}, 32'h1);
      chk("nognt_addr", imem_addr, model_pc);
      chk("nognt_valid", {31'h0, inst_valid}, 32'h0);
    end
    imem_rvalid = 1'b0;
    do_fetch(32'h1111_2222, 2, 1);
  endtask

  task automatic test_redirect_wait();
    inst_ready = 1'b1;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h8000_0102;
    tick();
    redirect = 1'b0;
    chk("rdw_still_wait", {31'h0, imem_req}, 32'h0);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("rdw_no_valid", {31'h0, inst_valid}, 32'h0);
    chk("rdw_req", {31'h0, imem_req}, 32'h1);
    chk("rdw_addr", imem_addr, 32'h8000_0100);
    inst_ready = 1'b0;
    model_pc = 32'h8000_0100;
    do_fetch(32'h0040_0113, 0, 0);
  endtask

  task automatic test_redirect_fetch();
    redirect = 1'b1;
    redirect_pc = 32'h8000_0403;
    tick();
    redirect = 1'b0;
    chk("rdf_nognt_req", {31'h0, imem_req}, 32'h1);
    chk("rdf_nognt_addr", imem_addr, 32'h8000_0400);
    imem_gnt = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h8000_0300;
    tick();
    imem_gnt = 1'b0;
    redirect = 1'b0;
    chk("rdf_gnt_wait", {31'h0, imem_req}, 32'h0);
    inst_ready = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0001;
    tick();
    imem_rvalid = 1'b0;
    inst_ready = 1'b0;
    chk("rdf_gnt_no_valid", {31'h0, inst_valid}, 32'h0);
    chk("rdf_gnt_addr", imem_addr, 32'h8000_0300);
    model_pc = 32'h8000_0300;
    do_fetch(32'h0050_0193, 0, 0);
  endtask

  task automatic test_redirect_rvalid();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0002;
    redirect = 1'b1;
    redirect_pc = 32'h8000_0500;
    tick();
    imem_rvalid = 1'b0;
    redirect = 1'b0;
    chk("rdr_no_valid", {31'h0, inst_valid}, 32'h0);
    chk("rdr_req", {31'h0, imem_req}, 32'h1);
    chk("rdr_addr", imem_addr, 32'h8000_0500);
    model_pc = 32'h8000_0500;
    do_fetch(32'h0060_0213, 0, 0);
  endtask

  task automatic test_redirect_hold();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0070_0293;
    exp_inst_q.push_back(32'h0070_0293);
    exp_pc_q.push_back(model_pc);
    tick();
    imem_rvalid = 1'b0;
    chk("rdh_valid", {31'h0, inst_valid}, 32'h1);
    inst_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h8000_0200;
    tick();
    inst_ready = 1'b0;
    redirect = 1'b0;
    chk("rdh_no_valid", {31'h0, inst_valid}, 32'h0);
    chk("rdh_addr", imem_addr, 32'h8000_0200);
    model_pc = 32'h8000_0200;
  endtask

  task automatic test_wrap();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    model_pc = 32'hFFFF_FFFC;
    do_fetch(32'h0080_0313, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
  endtask

  task automatic test_reset_mid_wait();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmw_req", {31'h0, imem_req}, 32'h1);
    chk("rmw_addr", imem_addr, 32'h8000_0000);
    inst_ready = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0003;
    tick();
    imem_rvalid = 1'b0;
    inst_ready = 1'b0;
    chk("rmw_ignored_req", {31'h0, imem_req}, 32'h1);
    chk("rmw_ignored_valid", {31'h0, inst_valid}, 32'h0);
    model_pc = 32'h8000_0000;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      do_fetch($urandom, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    chk("b2b_addr", imem_addr, model_pc);
  endtask

  initial begin
    reset = 1'b1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    inst_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    model_pc = 32'h8000_0000;
    test_reset();
    test_basic();
    test_stall();
    test_gnt_wait();
    test_redirect_wait();
    test_redirect_fetch();
    test_redirect_rvalid();
    test_redirect_hold();
    test_wrap();
    test_reset_mid_wait();
    test_back_to_back();
    tick();
    chk("sb_drained", exp_inst_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
